lavatory_lock_ctrl: RTL and testbench
=====================================

Name: lavatory_lock_ctrl

Overview:
- Produces the per-lavatory door-lock signals that the cabin availability indicator consumes: bit 0 is the female-only lavatory, bits 1 and 2 are unrestricted.
- Arbitrates passenger requests, reserves a lavatory, and tracks each lavatory through reserve, lock, unlock and cleaning.
- `door_locked` drives the indicator's sensor inputs directly.

Parameters:
- `RESV_TIMEOUT`, 8: number of cycles a granted lavatory stays reserved without a lock before it is released; must be at least 1.
- `CLEAN_CYCLES`, 4: number of cycles a lavatory spends in cleaning after unlock; must be at least 1.
- `CNT_W`, 4: width of the per-lavatory counter; must hold max(`RESV_TIMEOUT`, `CLEAN_CYCLES`).

Ports:
- `clk_2`  in  1  system clock; rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  passenger request.
- `req_female`  in  1  1 means the requester is female (may use lavatory 0); sampled with `req_valid`.
- `req_ready`  out  1  combinational; a suitable lavatory is available this cycle.
- `grant_valid`  out  1  registered one-cycle pulse after an accepted request.
- `grant_idx`  out  2  granted lavatory index (0..2); valid while `grant_valid` is 1.
- `lock_evt`  in  3  per-lavatory one-cycle pulse: occupant locks the door.
- `unlock_evt`  in  3  per-lavatory one-cycle pulse: occupant unlocks the door.
- `door_locked`  out  3  1 means the lavatory is in LOCKED (the sensor bit).
- `lav_busy`  out  3  1 means the lavatory is in any state other than FREE.

Behaviour:
- **State.** Three identical per-lavatory FSMs, each with states FREE, RESERVED, LOCKED, CLEANING, plus a `CNT_W`-bit counter.
- **Reset.** All FSMs go to FREE and all counters to 0. `grant_valid`, `grant_idx`, `door_locked` and `lav_busy` are 0. Outputs clear immediately on `reset` assertion, without waiting for a clock edge. Reset in the middle of any operation discards reservations, locks and cleaning.
- **Eligibility** (combinational), for lavatory i: `elig[i]` = (state is FREE) and not `lock_evt[i]`.
- **Ready.**
  - Female requester: `req_ready` = `elig[0]` or `elig[1]` or `elig[2]`.
  - Male requester: `req_ready` = `elig[1]` or `elig[2]`.
- **Selection.**
  - Female: the lowest eligible index, preferring 0, then 1, then 2.
  - Male: 1 if eligible, otherwise 2.
- **Accept.** A request is accepted when `req_valid` and `req_ready` are both 1 at an edge. At that edge:
  - the selected FSM moves to RESERVED with counter = `RESV_TIMEOUT`;
  - the next cycle shows `grant_valid` = 1 and `grant_idx` = the selected index.
- **No accept.** When no request is accepted, `grant_valid` = 0 and `grant_idx` holds its last value. A request that is not accepted needs no stall or hold; the requester re-presents it.
- **FREE.**
  - `lock_evt[i]` moves the FSM to LOCKED (walk-in lock without a request).
  - `unlock_evt[i]` is ignored.
- **RESERVED.**
  - `lock_evt[i]` moves the FSM to LOCKED.
  - Otherwise the counter decrements each cycle; when it is 1 with no lock, the FSM returns to FREE. The lavatory is therefore RESERVED for exactly `RESV_TIMEOUT` cycles.
  - `unlock_evt` is ignored. `lock_evt` and `unlock_evt` in the same cycle give LOCKED.
- **LOCKED.**
  - `door_locked[i]` = 1.
  - `unlock_evt[i]` moves the FSM to CLEANING with counter = `CLEAN_CYCLES`.
  - `lock_evt` is ignored.
- **CLEANING.**
  - `door_locked[i]` = 0 and `lav_busy[i]` = 1.
  - The counter decrements each cycle; at 1 the FSM goes to FREE, so the lavatory is in CLEANING for exactly `CLEAN_CYCLES` cycles.
  - All events are ignored.
- **Output timing.** `door_locked` and `lav_busy` are decoded from the state registers only, so an event sampled at edge k is visible after edge k with zero added latency.
- **Independence.** All three FSMs update in the same cycle with no interference. Only the grant path couples them.

Test Plan:
1. Reset; female `req_valid` → `req_ready` = 1; next cycle `grant_valid` = 1, `grant_idx` = 0, `lav_busy` = 001. Pulse `lock_evt` = 001 two cycles later → `door_locked` = 001.
2. Two male requests on consecutive cycles → grants with `grant_idx` 1 then 2, `lav_busy` = 110. Third male request → `req_ready` = 0, no grant. A female request in the same state → `req_ready` = 1, `grant_idx` = 0.
3. `RESV_TIMEOUT` = 8: grant lavatory 1 and never lock it → `lav_busy[1]` = 1 for exactly 8 cycles, then 0; a new male request is then granted to lavatory 1.
4. Lavatory 2 LOCKED, pulse `unlock_evt` = 100 → `door_locked[2]` = 0 and `lav_busy[2]` = 1 for exactly 4 cycles. A male request during this window with lavatory 1 busy gets `req_ready` = 0. Granted on the cycle `lav_busy[2]` falls.
5. All FREE; a female request and `lock_evt` = 001 in the same cycle → `grant_idx` = 1, `door_locked` = 001, `lav_busy` = 011.
6. Lavatories 0 and 2 LOCKED and lavatory 1 RESERVED; assert `reset` between clock edges → `door_locked` = 000, `lav_busy` = 000 and `grant_valid` = 0 immediately. After release the first female request gets `grant_idx` = 0.

Source files
------------

// File: rtl/lavatory_lock_ctrl_if.sv
// ---------------------------------------------------------------------------
// lavatory_lock_ctrl_if
// Groups the passenger request/grant handshake and the per-lavatory door
// event and status lines of lavatory_lock_ctrl.
//   req_valid   passenger request
//   req_female  requester may use lavatory 0 (sampled with req_valid)
//   req_ready   a suitable lavatory is available this cycle (combinational)
//   grant_valid one-cycle pulse after an accepted request
//   grant_idx   granted lavatory index, valid with grant_valid
//   lock_evt    per-lavatory one-cycle lock pulse
//   unlock_evt  per-lavatory one-cycle unlock pulse
//   door_locked per-lavatory LOCKED indication (indicator sensor bits)
//   lav_busy    per-lavatory "not FREE" indication
// master: requester / cabin side.  slave: the lock controller.
// ---------------------------------------------------------------------------
interface lavatory_lock_ctrl_if;
    logic       req_valid;
    logic       req_female;
    logic       req_ready;
    logic       grant_valid;
    logic [1:0] grant_idx;
    logic [2:0] lock_evt;
    logic [2:0] unlock_evt;
    logic [2:0] door_locked;
    logic [2:0] lav_busy;

    modport master (
        output req_valid, req_female, lock_evt, unlock_evt,
        input  req_ready, grant_valid, grant_idx, door_locked, lav_busy
    );

    modport slave (
        input  req_valid, req_female, lock_evt, unlock_evt,
        output req_ready, grant_valid, grant_idx, door_locked, lav_busy
    );
endinterface

// File: rtl/lavatory_lock_ctrl.sv
// ---------------------------------------------------------------------------
// lavatory_lock_ctrl
// Arbitrates passenger requests over three lavatories (0 = female-only,
// 1 and 2 unrestricted) and tracks each one through
// FREE -> RESERVED -> LOCKED -> CLEANING -> FREE, producing the door-lock
// bits consumed by the cabin availability indicator.
// Ports:
//   clk_2  system clock, rising edge
//   reset  asynchronous active-high reset
//   bus    lavatory_lock_ctrl_if.slave (request/grant handshake, door
//          events, door_locked / lav_busy status)
// Parameters:
//   RESV_TIMEOUT  cycles a granted lavatory stays reserved without a lock
//   CLEAN_CYCLES  cycles spent cleaning after unlock
//   CNT_W         per-lavatory counter width
// ---------------------------------------------------------------------------
module lavatory_lock_ctrl #(
    parameter int RESV_TIMEOUT = 8,
    parameter int CLEAN_CYCLES = 4,
    parameter int CNT_W        = 4
) (
    input  logic                 clk_2,
    input  logic                 reset,
    lavatory_lock_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_FREE     = 2'd0,
        ST_RESERVED = 2'd1,
        ST_LOCKED   = 2'd2,
        ST_CLEANING = 2'd3
    } lav_state_t;

    localparam logic [CNT_W-1:0] RESV_LOAD  = CNT_W'(RESV_TIMEOUT);
    localparam logic [CNT_W-1:0] CLEAN_LOAD = CNT_W'(CLEAN_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [2:0] elig;
    logic [2:0] grant_vec;
    logic [2:0] locked_vec;
    logic [2:0] busy_vec;
    logic       ready_int;
    logic [1:0] sel_idx;
    logic       accept;

    logic       grant_valid_reg;
    logic [1:0] grant_idx_reg;

    // Requester-dependent readiness and lavatory selection.  Eligibility
    // already excludes a lavatory whose lock pulse arrives this cycle, so a
    // walk-in lock and a grant can never target the same FSM.
    always_comb begin
        ready_int = 1'b0;
        sel_idx   = 2'd2;
        if (bus.req_female) begin
            ready_int = |elig;
            if (elig[0]) begin
                sel_idx = 2'd0;
            end else if (elig[1]) begin
                sel_idx = 2'd1;
            end else begin
                sel_idx = 2'd2;
            end
        end else begin
            ready_int = elig[1] | elig[2];
            sel_idx   = elig[1] ? 2'd1 : 2'd2;
        end
    end

    assign accept = bus.req_valid & ready_int;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_lav
            lav_state_t       state_reg;
            logic [CNT_W-1:0] cnt_reg;

            assign elig[gi]       = (state_reg == ST_FREE) && !bus.lock_evt[gi];
            assign grant_vec[gi]  = accept && (sel_idx == 2'(gi));
            assign locked_vec[gi] = (state_reg == ST_LOCKED);
            assign busy_vec[gi]   = (state_reg != ST_FREE);

            // The counter holds the remaining cycles in RESERVED/CLEANING;
            // leaving on the cycle it reads 1 gives exactly N cycles there.
            always_ff @(posedge clk_2 or posedge reset) begin
                if (reset) begin
                    state_reg <= ST_FREE;
                    cnt_reg   <= '0;
                end else begin
                    case (state_reg)
                        ST_FREE: begin
                            if (bus.lock_evt[gi]) begin
                                state_reg <= ST_LOCKED;
                            end else if (grant_vec[gi]) begin
                                state_reg <= ST_RESERVED;
                                cnt_reg   <= RESV_LOAD;
                            end
                        end
                        ST_RESERVED: begin
                            if (bus.lock_evt[gi]) begin
                                state_reg <= ST_LOCKED;
                                cnt_reg   <= '0;
                            end else if (cnt_reg == CNT_ONE) begin
                                state_reg <= ST_FREE;
                                cnt_reg   <= '0;
                            end else begin
                                cnt_reg <= cnt_reg - CNT_ONE;
                            end
                        end
                        ST_LOCKED: begin
                            if (bus.unlock_evt[gi]) begin
                                state_reg <= ST_CLEANING;
                                cnt_reg   <= CLEAN_LOAD;
                            end
                        end
                        ST_CLEANING: begin
                            if (cnt_reg == CNT_ONE) begin
                                state_reg <= ST_FREE;
                                cnt_reg   <= '0;
                            end else begin
                                cnt_reg <= cnt_reg - CNT_ONE;
                            end
                        end
                        default: begin
                            state_reg <= ST_FREE;
                            cnt_reg   <= '0;
                        end
                    endcase
                end
            end
        end
    endgenerate

    // grant_idx keeps its last value when nothing is accepted.
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            grant_valid_reg <= 1'b0;
            grant_idx_reg   <= 2'd0;
        end else begin
            grant_valid_reg <= accept;
            if (accept) begin
                grant_idx_reg <= sel_idx;
            end
        end
    end

    assign bus.req_ready   = ready_int;
    assign bus.grant_valid = grant_valid_reg;
    assign bus.grant_idx   = grant_idx_reg;
    assign bus.door_locked = locked_vec;
    assign bus.lav_busy    = busy_vec;

endmodule

// File: tb/tb_lavatory_lock_ctrl.sv
module tb_lavatory_lock_ctrl;

    localparam int RESV  = 8;
    localparam int CLEAN = 4;

    logic clk_2;
    logic reset;
    lavatory_lock_ctrl_if bus ();

    lavatory_lock_ctrl #(
        .RESV_TIMEOUT (RESV),
        .CLEAN_CYCLES (CLEAN),
        .CNT_W        (4)
    ) dut (
        .clk_2 (clk_2),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk_2 = 1'b0;
        forever #5 clk_2 = ~clk_2;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: each lavatory is a mode (0 free, 1 reserved,
    // 2 locked, 3 cleaning) plus the absolute cycle number at which a timed
    // mode ends.  Requests are served from a preference list.
    // ------------------------------------------------------------------
    int m_cyc;
    int m_mode   [3];
    int m_expire [3];
    int m_mode_n [3];
    int m_exp_n  [3];
    int m_gv;
    int m_gidx;
    logic m_ready;
    int   m_sel;
    logic [2:0] m_busy;
    logic [2:0] m_locked;

    always_comb begin
        m_ready = 1'b0;
        m_sel   = 0;
        for (int k = (bus.req_female ? 0 : 1); k < 3; k++) begin
            if (!m_ready && m_mode[k] == 0 && !bus.lock_evt[k]) begin
                m_ready = 1'b1;
                m_sel   = k;
            end
        end
        for (int i = 0; i < 3; i++) begin
            m_busy[i]   = (m_mode[i] != 0);
            m_locked[i] = (m_mode[i] == 2);
            m_mode_n[i] = m_mode[i];
            m_exp_n[i]  = m_expire[i];
            case (m_mode[i])
                0: if (bus.lock_evt[i]) m_mode_n[i] = 2;
                   else if (bus.req_valid && m_ready && m_sel == i) begin
                       m_mode_n[i] = 1;
                       m_exp_n[i]  = m_cyc + 1 + RESV;
                   end
                1: if (bus.lock_evt[i]) m_mode_n[i] = 2;
                   else if (m_cyc + 1 >= m_expire[i]) m_mode_n[i] = 0;
                2: if (bus.unlock_evt[i]) begin
                       m_mode_n[i] = 3;
                       m_exp_n[i]  = m_cyc + 1 + CLEAN;
                   end
                default: if (m_cyc + 1 >= m_expire[i]) m_mode_n[i] = 0;
            endcase
        end
    end

    always @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            m_cyc <= 0;
            m_gv  <= 0;
            m_gidx <= 0;
            for (int i = 0; i < 3; i++) begin
                m_mode[i]   <= 0;
                m_expire[i] <= 0;
            end
        end else begin
            m_cyc <= m_cyc + 1;
            m_gv  <= (bus.req_valid && m_ready) ? 1 : 0;
            if (bus.req_valid && m_ready) m_gidx <= m_sel;
            for (int i = 0; i < 3; i++) begin
                m_mode[i]   <= m_mode_n[i];
                m_expire[i] <= m_exp_n[i];
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk_2) begin
        check("cyc_req_ready",   bus.req_ready,   m_ready);
        check("cyc_grant_valid", bus.grant_valid, m_gv[0]);
        check("cyc_grant_idx",   bus.grant_idx,   m_gidx[1:0]);
        check("cyc_door_locked", bus.door_locked, m_locked);
        check("cyc_lav_busy",    bus.lav_busy,    m_busy);
        if (bus.grant_valid)
            $display("grant: idx=%0d busy=%b locked=%b t=%0t",
                     bus.grant_idx, bus.lav_busy, bus.door_locked, $time);
    end

    // ------------------------------------------------------------------
    // Directed stimulus with literal expectations
    // ------------------------------------------------------------------
    task automatic step;
        @(posedge clk_2);
        #1;
    endtask

    task automatic clear_inputs;
        bus.req_valid  = 1'b0;
        bus.req_female = 1'b0;
        bus.lock_evt   = 3'b000;
        bus.unlock_evt = 3'b000;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        clear_inputs();
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        do_reset();

        // 1: female grant, then lock
        check("t1_rst_gv",   bus.grant_valid, 0);
        check("t1_rst_busy", bus.lav_busy,    3'b000);
        check("t1_rst_lock", bus.door_locked, 3'b000);
        bus.req_valid = 1'b1; bus.req_female = 1'b1;
        #1 check("t1_ready", bus.req_ready, 1);
        step();
        clear_inputs();
        check("t1_gv",   bus.grant_valid, 1);
        check("t1_gidx", bus.grant_idx,   0);
        check("t1_busy", bus.lav_busy,    3'b001);
        step();
        bus.lock_evt = 3'b001;
        step();
        clear_inputs();
        check("t1_lock", bus.door_locked, 3'b001);

        // 2: male requests fill 1 and 2, then refused; female gets 0
        do_reset();
        bus.req_valid = 1'b1; bus.req_female = 1'b0;
        step();
        check("t2_gidx_a", bus.grant_idx, 1);
        step();
        check("t2_gidx_b", bus.grant_idx, 2);
        check("t2_busy",   bus.lav_busy,  3'b110);
        #1 check("t2_male_ready", bus.req_ready, 0);
        step();
        check("t2_no_gv",  bus.grant_valid, 0);
        check("t2_hold_idx", bus.grant_idx, 2);
        bus.req_female = 1'b1;
        #1 check("t2_fem_ready", bus.req_ready, 1);
        step();
        clear_inputs();
        check("t2_fem_gv",   bus.grant_valid, 1);
        check("t2_fem_gidx", bus.grant_idx,   0);

        // 3: reservation timeout on lavatory 1
        do_reset();
        bus.req_valid = 1'b1; bus.req_female = 1'b0;
        step();
        clear_inputs();
        check("t3_gidx", bus.grant_idx, 1);
        check("t3_busy0", bus.lav_busy[1], 1);
        for (int k = 1; k <= RESV; k++) begin
            step();
            check($sformatf("t3_busy%0d", k), bus.lav_busy[1], (k < RESV) ? 1 : 0);
        end
        bus.req_valid = 1'b1;
        step();
        clear_inputs();
        check("t3_regrant_gv",  bus.grant_valid, 1);
        check("t3_regrant_idx", bus.grant_idx,   1);

        // 4: cleaning window on lavatory 2
        do_reset();
        bus.lock_evt = 3'b100;
        bus.req_valid = 1'b1; bus.req_female = 1'b0;
        step();
        clear_inputs();
        check("t4_gidx", bus.grant_idx, 1);
        check("t4_lock", bus.door_locked, 3'b100);
        bus.unlock_evt = 3'b100;
        step();
        clear_inputs();
        bus.req_valid = 1'b1;
        #1;
        check("t4_clean_lock0", bus.door_locked[2], 0);
        check("t4_clean_busy0", bus.lav_busy[2],    1);
        check("t4_ready0",      bus.req_ready,      0);
        for (int k = 1; k <= CLEAN; k++) begin
            step();
            check($sformatf("t4_busy%0d", k),  bus.lav_busy[2], (k < CLEAN) ? 1 : 0);
            check($sformatf("t4_ready%0d", k), bus.req_ready,   (k == CLEAN) ? 1 : 0);
            check($sformatf("t4_gv%0d", k),    bus.grant_valid, 0);
        end
        step();
        clear_inputs();
        check("t4_gv",    bus.grant_valid, 1);
        check("t4_gidx2", bus.grant_idx,   2);

        // 5: female request and walk-in lock of 0 in the same cycle
        do_reset();
        bus.req_valid = 1'b1; bus.req_female = 1'b1; bus.lock_evt = 3'b001;
        #1 check("t5_ready", bus.req_ready, 1);
        step();
        clear_inputs();
        check("t5_gidx", bus.grant_idx,   1);
        check("t5_lock", bus.door_locked, 3'b001);
        check("t5_busy", bus.lav_busy,    3'b011);

        // 6: asynchronous reset mid-operation
        do_reset();
        bus.lock_evt = 3'b101;
        step();
        clear_inputs();
        bus.req_valid = 1'b1;
        step();
        clear_inputs();
        check("t6_pre_gv",   bus.grant_valid, 1);
        check("t6_pre_lock", bus.door_locked, 3'b101);
        check("t6_pre_busy", bus.lav_busy,    3'b111);
        #2 reset = 1'b1;
        #1;
        check("t6_rst_lock", bus.door_locked, 3'b000);
        check("t6_rst_busy", bus.lav_busy,    3'b000);
        check("t6_rst_gv",   bus.grant_valid, 0);
        step();
        reset = 1'b0;
        bus.req_valid = 1'b1; bus.req_female = 1'b1;
        step();
        clear_inputs();
        check("t6_gv",   bus.grant_valid, 1);
        check("t6_gidx", bus.grant_idx,   0);

        step();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
